// File: rtl/spike_window_classifier_pkg.sv
// Shared types and constants for the SNN classification readout.
// The default N/CNTBITS are also consumed by the neuron layer top level.
package spike_window_classifier_pkg;

  localparam int DEFAULT_N       = 4;
  localparam int DEFAULT_CNTBITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a derived width is always usable.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spike_counter_sat.sv
// Per-neuron saturating spike counter; zeroed at each window end so the
// final-cycle spike lands only in the parent's snapshot.
module spike_counter_sat #(
  parameter int CNTBITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               spike_in,
  input  logic               window_end,
  output logic [CNTBITS-1:0] count_out
);

  function automatic logic [CNTBITS-1:0] sat_inc(input logic [CNTBITS-1:0] v,
                                                 input logic             b);
    return (b && (v != '1)) ? v + CNTBITS'(1) : v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_out <= '0;
    end else if (clear || window_end) begin
      count_out <= '0;
    end else if (enable) begin
      count_out <= sat_inc(count_out, spike_in);
    end
  end

endmodule

// File: rtl/spike_window_classifier.sv
// Windowed spike counting with snapshot, sequential argmax scan and a
// valid/ready result port; windows ending while busy are dropped (overrun).
module spike_window_classifier
  import spike_window_classifier_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int CNTBITS = DEFAULT_CNTBITS,
  parameter int WINDOW  = 15,
  parameter int WBITS   = clog2(WINDOW),
  parameter int IDXW    = clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [N-1:0]         output_spikes,
  input  logic                 result_ready,
  output logic                 result_valid,
  output logic [IDXW-1:0]      winner_idx,
  output logic [CNTBITS-1:0]   winner_count,
  output logic                 no_spike,
  output logic [N*CNTBITS-1:0] spike_counts,
  output logic                 overrun
);

  localparam logic [WBITS-1:0] LAST_W   = WBITS'(WINDOW - 1);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N - 1);

  function automatic logic [CNTBITS-1:0] sat_inc(input logic [CNTBITS-1:0] v,
                                                 input logic             b);
    return (b && (v != '1)) ? v + CNTBITS'(1) : v;
  endfunction

  state_t              state, state_next;
  logic [WBITS-1:0]    wcnt;
  logic [IDXW-1:0]     idx;
  logic [IDXW-1:0]     bidx;
  logic [CNTBITS-1:0]  best;
  logic [CNTBITS-1:0]  cnt  [N];
  logic [CNTBITS-1:0]  snap [N];
  logic                window_end;

  assign window_end = enable && (wcnt == LAST_W);

  for (genvar g = 0; g < N; g++) begin : g_cnt
    spike_counter_sat #(.CNTBITS(CNTBITS)) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .enable    (enable),
      .spike_in  (output_spikes[g]),
      .window_end(window_end),
      .count_out (cnt[g])
    );
    assign spike_counts[g*CNTBITS +: CNTBITS] = snap[g];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (window_end)        state_next = SCAN;
      SCAN:    if (idx == LAST_IDX)   state_next = HOLD;
      HOLD:    if (result_ready)      state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Winner fields are only meaningful while the result is offered.
  always_comb begin
    result_valid = (state == HOLD);
    winner_idx   = result_valid ? bidx : '0;
    winner_count = result_valid ? best : '0;
    no_spike     = result_valid && (best == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt    <= '0;
      overrun <= 1'b0;
      idx     <= '0;
      best    <= '0;
      bidx    <= '0;
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else if (clear) begin
      wcnt    <= '0;
      overrun <= 1'b0;
      idx     <= '0;
      best    <= '0;
      bidx    <= '0;
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else begin
      if (enable) wcnt <= window_end ? '0 : wcnt + WBITS'(1);
      if (window_end && (state != IDLE)) overrun <= 1'b1;
      // The final-cycle spike is folded into the snapshot directly.
      if (window_end && (state == IDLE)) begin
        for (int i = 0; i < N; i++) snap[i] <= sat_inc(cnt[i], output_spikes[i]);
        idx  <= '0;
        best <= '0;
        bidx <= '0;
      end else if (state == SCAN) begin
        if (snap[idx] > best) begin
          best <= snap[idx];
          bidx <= idx;
        end
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed + randomized bench for spike_window_classifier with a
// window-level reference model (counts per window, argmax at snapshot).
module tb_spike_window_classifier;

  localparam int N       = 4;
  localparam int CNTBITS = 4;
  localparam int WINDOW  = 20;
  localparam int WBITS   = 5;
  localparam int IDXW    = 2;
  localparam int MAXC    = (1 << CNTBITS) - 1;

  logic                 clk;
  logic                 reset_n;
  logic                 enable;
  logic                 clear;
  logic [N-1:0]         output_spikes;
  logic                 result_ready;
  logic                 result_valid;
  logic [IDXW-1:0]      winner_idx;
  logic [CNTBITS-1:0]   winner_count;
  logic                 no_spike;
  logic [N*CNTBITS-1:0] spike_counts;
  logic                 overrun;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt [N];
  int m_snap [N];
  int m_wpos;
  int m_mode;      // 0 idle, 1 scanning, 2 holding
  int m_left;
  int m_widx;
  int m_wcnt;
  bit m_ovr;

  spike_window_classifier #(
    .N(N), .CNTBITS(CNTBITS), .WINDOW(WINDOW), .WBITS(WBITS), .IDXW(IDXW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear        (clear),
    .output_spikes(output_spikes),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .winner_idx   (winner_idx),
    .winner_count (winner_count),
    .no_spike     (no_spike),
    .spike_counts (spike_counts),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_snap[i] = 0;
    end
    m_wpos = 0; m_mode = 0; m_left = 0; m_widx = 0; m_wcnt = 0; m_ovr = 0;
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_edge(input bit en, input logic [N-1:0] sp, input bit rdy, input bit clr);
    bit wend;
    int pre;
    if (clr) begin
      model_reset();
      return;
    end
    wend = en && (m_wpos == WINDOW - 1);
    pre  = m_mode;
    if (pre == 2 && rdy) m_mode = 0;
    else if (pre == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
    if (wend) begin
      if (pre == 0) begin
        m_wcnt = 0; m_widx = 0;
        for (int i = 0; i < N; i++) begin
          m_snap[i] = sat(m_cnt[i] + int'(sp[i]));
          if (m_snap[i] > m_wcnt) begin
            m_wcnt = m_snap[i];
            m_widx = i;
          end
        end
        m_mode = 1;
        m_left = N;
      end else begin
        m_ovr = 1;
      end
    end
    if (en) begin
      for (int i = 0; i < N; i++) m_cnt[i] = wend ? 0 : sat(m_cnt[i] + int'(sp[i]));
      m_wpos = wend ? 0 : m_wpos + 1;
    end
  endtask

  task automatic compare_model();
    logic [N*CNTBITS-1:0] pk;
    for (int i = 0; i < N; i++) pk[i*CNTBITS +: CNTBITS] = CNTBITS'(m_snap[i]);
    check("result_valid", 32'(result_valid), 32'(m_mode == 2));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("spike_counts", 32'(spike_counts), 32'(pk));
    if (m_mode == 2) begin
      check("winner_idx", 32'(winner_idx), 32'(m_widx));
      check("winner_count", 32'(winner_count), 32'(m_wcnt));
      check("no_spike", 32'(no_spike), 32'(m_wcnt == 0));
    end
  endtask

  task automatic step(input bit en, input logic [N-1:0] sp, input bit rdy, input bit clr);
    enable = en; output_spikes = sp; result_ready = rdy; clear = clr;
    @(posedge clk);
    model_edge(en, sp, rdy, clr);
    #1;
    compare_model();
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 0; k < N + 4; k++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      lat++;
      if (result_valid) break;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(result_valid), 0);
    check({tag, "_idx"}, 32'(winner_idx), 0);
    check({tag, "_count"}, 32'(winner_count), 0);
    check({tag, "_nospike"}, 32'(no_spike), 0);
    check({tag, "_counts"}, 32'(spike_counts), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    int lat;
    logic [N-1:0] sp;
    logic [IDXW-1:0] held_idx;
    logic [CNTBITS-1:0] held_cnt;
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0;
    output_spikes = '0; result_ready = 1'b0;
    model_reset();
    #12;
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Basic winner: neuron 2 spikes every cycle (saturates at 15)
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < WINDOW; c++) step(1'b1, 4'b0100, 1'b0, 1'b0);
    wait_valid(lat);
    check("basic_latency", 32'(lat), N);
    check("basic_idx", 32'(winner_idx), 2);
    check("basic_count", 32'(winner_count), 15);
    check("basic_counts", 32'(spike_counts), 32'h0F00);
    check("basic_nospike", 32'(no_spike), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("basic_xfer", 32'(result_valid), 0);

    // Tie-break: neurons 1 and 3 spike 5 times, neuron 0 twice
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < WINDOW; c++) begin
      sp = '0;
      if (c < 5) sp = sp | 4'b1010;
      if (c < 2) sp = sp | 4'b0001;
      step(1'b1, sp, 1'b0, 1'b0);
    end
    wait_valid(lat);
    check("tie_idx", 32'(winner_idx), 1);
    check("tie_count", 32'(winner_count), 5);
    step(1'b0, '0, 1'b1, 1'b0);

    // Silent window
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < WINDOW; c++) step(1'b1, '0, 1'b0, 1'b0);
    wait_valid(lat);
    check("silent_nospike", 32'(no_spike), 1);
    check("silent_idx", 32'(winner_idx), 0);
    check("silent_count", 32'(winner_count), 0);
    check("silent_counts", 32'(spike_counts), 0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Gating: enable low 5 cycles mid-window, window spans 25 clocks
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < WINDOW + 5; c++) step(!(c >= 8 && c < 13), 4'b0001, 1'b0, 1'b0);
    wait_valid(lat);
    check("gate_latency", 32'(lat), N);
    check("gate_idx", 32'(winner_idx), 0);
    check("gate_count", 32'(winner_count), 15);
    check("gate_counts", 32'(spike_counts), 32'h000F);
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic across several windows
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 4 * WINDOW + 20; c++)
      step($urandom_range(0, 7) != 0, N'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Backpressure: result held across a second window -> overrun
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < WINDOW; c++) step(1'b1, N'($urandom), 1'b0, 1'b0);
    wait_valid(lat);
    held_idx = winner_idx;
    held_cnt = winner_count;
    for (int c = 0; c < WINDOW; c++) step(1'b1, N'($urandom), 1'b0, 1'b0);
    check("bp_overrun", 32'(overrun), 1);
    check("bp_valid", 32'(result_valid), 1);
    check("bp_idx_stable", 32'(winner_idx), 32'(held_idx));
    check("bp_cnt_stable", 32'(winner_count), 32'(held_cnt));
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_xfer", 32'(result_valid), 0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("bp_clear_overrun", 32'(overrun), 0);

    // Async reset during SCAN, then restart timing
    for (int c = 0; c < WINDOW; c++) step(1'b1, 4'b0010, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("areset");
    model_reset();
    #2 reset_n = 1'b1;
    for (int c = 0; c < WINDOW; c++) step(1'b1, 4'b0010, 1'b0, 1'b0);
    wait_valid(lat);
    check("areset_latency", 32'(lat), N);
    check("areset_idx", 32'(winner_idx), 1);

    // Clear during HOLD, then restart timing
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_valid", 32'(result_valid), 0);
    for (int c = 0; c < WINDOW; c++) step(1'b1, 4'b1000, 1'b0, 1'b0);
    wait_valid(lat);
    check("clr_latency", 32'(lat), N);
    check("clr_idx", 32'(winner_idx), 3);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
- Sits directly downstream of the neuron layer and consumes its N-bit output_spikes vector.
- Counts spikes per neuron over a fixed window of enabled cycles, then snapshots the counts.
- Finds the winning neuron with a sequential argmax scan and presents the result over a valid/ready handshake.
- Provides the classification readout for the SNN.

Parameters:
- N, 4, number of neurons / spike inputs (≥2).
- CNTBITS, 4, width of each per-neuron saturating spike counter.
- WINDOW, 15, enabled cycles per classification window (≥1).
- WBITS, 4, window counter width; must hold WINDOW-1.
- IDXW, 2, winner index width; must satisfy 2^IDXW ≥ N.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  same enable that drives the layer; spikes are counted and the window advances only when high.
- clear  in  1  synchronous restart of the window and all state.
- output_spikes  in  N  spike vector from the neuron layer; bit i belongs to neuron i.
- result_ready  in  1  consumer accepts the result.
- result_valid  out  1  result is available and stable.
- winner_idx  out  IDXW  index of the neuron with the maximum count.
- winner_count  out  CNTBITS  count of the winning neuron.
- no_spike  out  1  all snapshot counts were zero.
- spike_counts  out  N*CNTBITS  snapshot counts; neuron i occupies [i*CNTBITS +: CNTBITS].
- overrun  out  1  sticky flag: a window result was dropped.

Behaviour:
- Reset (reset_n=0, async): every register and output goes to 0, and FSM = IDLE. Deassertion is used synchronously.
- Live counters:
  - On each edge with enable=1, cnt[i] += output_spikes[i].
  - Counters saturate at 2^CNTBITS-1.
  - With enable=0, counters and the window counter hold and spikes are ignored.
- Window counter wcnt:
  - Increments on enabled cycles.
  - Window end is defined as enable=1 && wcnt==WINDOW-1.
  - At window end, wcnt wraps to 0 and live counters go to 0 on the same edge. Spikes present in that final cycle are included in the snapshot, not carried into the next window.
- Snapshot at window end:
  - If FSM == IDLE: snap[i] = cnt[i] + output_spikes[i] (saturated), which is driven on spike_counts, and FSM goes to SCAN with idx=0, best=0, bidx=0.
  - Otherwise the snapshot is discarded, overrun is set to 1, and the held result is unchanged.
- FSM states: IDLE, SCAN, HOLD.
  - SCAN: one neuron per cycle, idx 0..N-1. If snap[idx] > best (strict), then best=snap[idx] and bidx=idx, so ties resolve to the lowest index. After idx==N-1 is evaluated, go to HOLD.
  - HOLD: result_valid=1. winner_idx=bidx, winner_count=best, no_spike=(best==0). When best==0, winner_idx=0.
- Latency: snapshot taken at edge t0; result_valid rises after edge t0+N.
- Handshake:
  - Result outputs and spike_counts stay stable while result_valid=1.
  - An edge with result_valid && result_ready is a transfer. After it, result_valid=0 and FSM = IDLE.
  - result_ready is ignored while result_valid=0.
  - The next window may snapshot on the same edge as a transfer; that snapshot is dropped (FSM was not IDLE) and overrun is set.
- Counting runs continuously during SCAN and HOLD, independent of the FSM.
- clear=1 (synchronous, has priority over all else): cnt, wcnt, snap, best, bidx, result_valid and overrun go to 0, and FSM = IDLE. clear=1 during SCAN/HOLD aborts the result.
- Simultaneous clear and window end: clear wins and no snapshot is taken.
- Async reset asserted mid-SCAN or mid-HOLD: outputs go to 0 immediately.
- Width rules: comparisons are unsigned and CNTBITS wide. The saturating add has a 1-bit increment and no wrap.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE/SCAN/HOLD, 2-bit encoding);
  - the clog2 helper used to derive IDXW/WBITS;
  - default N/CNTBITS constants, shared with the neuron layer top level.
- Natural sub-module: spike_counter_sat, one per neuron.
  - Ports: clk, reset_n, clear, enable, spike_in, window_end, count_out.
  - Handles the saturating increment and the zeroing at window end.
- Window counter, snapshot, scan FSM and handshake stay in the parent.

Test Plan:
- Basic winner (N=4, CNTBITS=4, WINDOW=15): neuron 2 spikes every enabled cycle, others silent, result_ready=1 → result_valid 4 cycles after snapshot edge; winner_idx=2, winner_count=15, spike_counts={0,0,15,0}, no_spike=0.
- Tie-break: neurons 1 and 3 each spike 5 times, neuron 0 spikes 2 times → winner_idx=1, winner_count=5.
- Silent window: no spikes → no_spike=1, winner_idx=0, winner_count=0, spike_counts all 0.
- Saturation and gating: WINDOW=20, neuron 0 spikes every cycle, enable low for 5 cycles mid-window → snapshot after 20 enabled cycles; winner_count=15 (saturated); the window spans 25 clocks.
- Backpressure/overrun: hold result_ready=0 across two windows → first result stays stable, overrun=1 at the second window end; then ready=1 → result_valid drops and FSM = IDLE; clear=1 → overrun=0.
- Reset/clear mid-operation: assert reset_n=0 during SCAN → all outputs 0 asynchronously; after release, the first result appears after exactly WINDOW enabled cycles + N. Repeating with clear during HOLD gives the same restart timing.
